// File: rtl/axi_rd_traffic_chk.sv
// axi_rd_traffic_chk
//   AXI4 read-only traffic master and checker. Issues num_bursts INCR read bursts of
//   burst_len+1 beats each, one outstanding at a time, starting at base_addr and
//   advancing by one burst's worth of bytes per burst. Every returned beat is checked
//   for data, response, ID and RLAST position; failures accumulate in a saturating
//   error counter, accepted beats in a wrapping beat counter.
// Ports
//   axi_clk, axi_resetn            clock, synchronous active-low reset
//   start, base_addr, burst_len,   run request and run configuration (sampled in IDLE)
//   num_bursts
//   busy, done                     run in progress / one-cycle completion pulse
//   err_count, beat_count          per-run statistics, held after completion
//   m_axi_ar*                      AR channel (master side)
//   m_axi_r*                       R channel (master side)
//
// state  | meaning
// IDLE   | waiting for start; counters hold previous run's totals
// ADDR   | presenting AR for the current burst
// DATA   | accepting R beats of the current burst
// DONE   | run finished; done pulse is launched
module axi_rd_traffic_chk #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    ID_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] EXPECT_DATA = '0
) (
  input  logic                  axi_clk,
  input  logic                  axi_resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            burst_len,
  input  logic [15:0]           num_bursts,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_count,
  output logic [31:0]           beat_count,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  arvalid_q, arvalid_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic                  rready_q, rready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [15:0]           err_q, err_d;
  logic [31:0]           beat_q, beat_d;
  logic [15:0]           idx_q, idx_d;
  logic [15:0]           nb_q, nb_d;
  logic [ID_WIDTH-1:0]   exp_id_q, exp_id_d;
  logic [8:0]            left_q, left_d;

  logic                  ar_hs;
  logic                  r_hs;
  logic                  beat_err;
  logic [15:0]           idx_inc;
  logic [ADDR_WIDTH-1:0] burst_bytes;

  assign ar_hs = m_axi_arvalid & m_axi_arready;
  // rready is only ever high in DATA, so this also excludes beats outside DATA.
  assign r_hs  = m_axi_rvalid & rready_q;

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    rready_d  = rready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    nb_d      = nb_q;
    exp_id_d  = exp_id_q;
    left_d    = left_q;

    // One error per beat regardless of how many individual checks fail.
    beat_err    = (m_axi_rdata != EXPECT_DATA) || (m_axi_rresp != 2'b00) ||
                  (m_axi_rid != exp_id_q) || (m_axi_rlast != (left_q == 9'd1));
    idx_inc     = idx_q + 16'd1;
    burst_bytes = ADDR_WIDTH'({1'b0, arlen_q} + 9'd1) * ADDR_WIDTH'(BYTES);

    unique case (state_q)
      S_IDLE: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        if (start) begin
          nb_d     = num_bursts;
          arlen_d  = burst_len;
          araddr_d = base_addr;
          arid_d   = '0;
          idx_d    = '0;
          err_d    = '0;
          beat_d   = '0;
          busy_d   = 1'b1;
          state_d  = (num_bursts == 16'd0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        // First ADDR cycle keeps arvalid low, giving the idle cycle after the last beat.
        if (ar_hs) begin
          arvalid_d = 1'b0;
          exp_id_d  = arid_q;
          left_d    = {1'b0, arlen_q} + 9'd1;
          rready_d  = 1'b1;
          state_d   = S_DATA;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      S_DATA: begin
        if (r_hs) begin
          beat_d = beat_q + 32'd1;
          left_d = left_q - 9'd1;
          if (beat_err && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
          end
          // Burst length is governed by arlen only; a wrong rlast is just an error.
          if (left_q == 9'd1) begin
            rready_d = 1'b0;
            idx_d    = idx_inc;
            araddr_d = araddr_q + burst_bytes;
            arid_d   = ID_WIDTH'(idx_inc);
            state_d  = (idx_inc == nb_q) ? S_DONE : S_ADDR;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      state_q   <= S_IDLE;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      beat_q    <= '0;
      idx_q     <= '0;
      nb_q      <= '0;
      exp_id_q  <= '0;
      left_q    <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      beat_q    <= beat_d;
      idx_q     <= idx_d;
      nb_q      <= nb_d;
      exp_id_q  <= exp_id_d;
      left_q    <= left_d;
    end
  end

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_arid    = arid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_rready  = rready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_count     = err_q;
  assign beat_count    = beat_q;

endmodule

// File: tb/tb_axi_rd_traffic_chk.sv
// Testbench for axi_rd_traffic_chk: a behavioural AXI read slave driven from the
// bench, with the expected AR sequence and per-beat error/beat totals computed
// from the checker rules on the bench side.
module tb_axi_rd_traffic_chk;

  localparam logic [31:0] EXP = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  burst_len;
  logic [15:0] num_bursts;
  logic        busy, done;
  logic [15:0] err_count;
  logic [31:0] beat_count;
  logic [7:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid, arready;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_rd_traffic_chk #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(8), .EXPECT_DATA(EXP)
  ) dut (
    .axi_clk(clk), .axi_resetn(rstn), .start(start), .base_addr(base_addr),
    .burst_len(burst_len), .num_bursts(num_bursts), .busy(busy), .done(done),
    .err_count(err_count), .beat_count(beat_count), .m_axi_arid(arid),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  // Runs one programmed sequence with the bench acting as the read slave.
  // fmode 0: clean, 1: rlast early on beat 2 and missing + SLVERR on beat 4,
  // 2: random corruption of id/resp/rlast/data.
  task automatic run_traffic(input logic [31:0] b, input logic [7:0] len,
                             input logic [15:0] n, input logic [31:0] cdata,
                             input int fmode, input int ar_delay, input bit toggle,
                             input bit poke, output int e_err, output int e_beats,
                             output int ar_bad, output int stab_bad, output int n_done,
                             output int n_ar, output bit tmo);
    logic [31:0] exp_addr, p_addr, d;
    logic [7:0]  p_id, ri;
    logic [1:0]  rs;
    logic        rl, ar_hs, mm, pend, r_act;
    int          beat, cur_id, ar_wait, post;
    e_err = 0; e_beats = 0; ar_bad = 0; stab_bad = 0; n_done = 0; n_ar = 0; tmo = 1'b0;
    pend = 1'b0; r_act = 1'b0; beat = 0; cur_id = 0; ar_wait = 0; post = -1;
    p_addr = '0; p_id = '0;
    start = 1'b1; base_addr = b; burst_len = len; num_bursts = n;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = $urandom; burst_len = 8'($urandom); num_bursts = 16'($urandom);
    exp_addr = b;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (done) begin
        n_done++;
        if (post < 0) post = 0;
      end
      if (post >= 0) begin
        if (post == 3) break;
        post++;
      end
      if (poke && cyc == 7) begin
        start = 1'b1; base_addr = $urandom; burst_len = 8'($urandom); num_bursts = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      if (arvalid) begin
        if (pend && (araddr !== p_addr || arid !== p_id || arlen !== len)) stab_bad++;
        arready = (ar_wait >= ar_delay);
        ar_wait++;
      end else begin
        arready = 1'($urandom_range(0, 1));
      end
      ar_hs = arvalid && arready;
      if (ar_hs) begin
        if (araddr !== exp_addr || arid !== 8'(n_ar) || arlen !== len) ar_bad++;
        n_ar++;
        exp_addr = exp_addr + 32'((int'(len) + 1) * 4);
        pend = 1'b0;
        ar_wait = 0;
      end else begin
        pend = arvalid;
        p_addr = araddr;
        p_id = arid;
      end
      if (r_act) begin
        rvalid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        d = cdata; rs = 2'b00; rl = (beat == int'(len)); ri = 8'(cur_id);
        if (fmode == 1) begin
          if (beat == 1) rl = 1'b1;
          if (beat == 3) begin rl = 1'b0; rs = 2'b10; end
        end else if (fmode == 2) begin
          if ($urandom_range(0, 7) == 0) ri = ri ^ 8'(1 << $urandom_range(0, 7));
          if ($urandom_range(0, 7) == 0) rs = 2'($urandom_range(1, 3));
          if ($urandom_range(0, 7) == 0) rl = ~rl;
          if ($urandom_range(0, 7) == 0) d = $urandom;
        end
        rdata = d; rresp = rs; rlast = rl; rid = ri;
        if (rvalid && rready) begin
          mm = (d != EXP) || (rs != 2'b00) || (ri != 8'(cur_id)) || (rl != (beat == int'(len)));
          e_beats++;
          if (mm && e_err < 65535) e_err++;
          beat++;
          if (beat == int'(len) + 1) r_act = 1'b0;
        end
      end else begin
        rvalid = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
        rdata = $urandom; rresp = 2'($urandom); rlast = 1'($urandom); rid = 8'($urandom);
      end
      if (ar_hs) begin
        r_act = 1'b1;
        beat = 0;
        cur_id = n_ar - 1;
      end
      @(posedge clk); #1;
    end
    if (post < 3) tmo = 1'b1;
    start = 1'b0; rvalid = 1'b0; arready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({arvalid, arid, araddr, arlen, rready, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %h required 0", {arvalid, arid, araddr, arlen, rready, busy, done});
    end
    n_cmp++;
    if (err_count !== 16'd0 || beat_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_counts: got err=%0d beats=%0d required 0/0", err_count, beat_count);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input string tag, input logic [31:0] b, input logic [7:0] len,
                            input logic [15:0] n, input logic [31:0] cdata, input int fmode,
                            input int ar_delay, input bit toggle, input bit poke);
    int e_err, e_beats, ar_bad, stab_bad, n_done, n_ar;
    bit tmo;
    run_traffic(b, len, n, cdata, fmode, ar_delay, toggle, poke,
                e_err, e_beats, ar_bad, stab_bad, n_done, n_ar, tmo);
    n_cmp++;
    if (tmo) begin
      n_bad++;
      $display("FAIL %s_timeout: done not seen within budget", tag);
    end
    n_cmp++;
    if (beat_count !== 32'(e_beats) || e_beats != int'(n) * (int'(len) + 1)) begin
      n_bad++;
      $display("FAIL %s_beats: got %0d required %0d", tag, beat_count, int'(n) * (int'(len) + 1));
    end
    n_cmp++;
    if (err_count !== 16'(e_err)) begin
      n_bad++;
      $display("FAIL %s_errs: got %0d required %0d", tag, err_count, e_err);
    end
    n_cmp++;
    if (n_ar != int'(n) || ar_bad != 0) begin
      n_bad++;
      $display("FAIL %s_ar: got %0d AR (%0d wrong) required %0d", tag, n_ar, ar_bad, n);
    end
    n_cmp++;
    if (n_done != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done: got %0d pulses busy=%0d required 1 pulse busy=0", tag, n_done, busy);
    end
    n_cmp++;
    if (stab_bad != 0) begin
      n_bad++;
      $display("FAIL %s_ar_stable: got %0d changes while waiting required 0", tag, stab_bad);
    end
  endtask

  task automatic test_zero_bursts();
    int arv;
    arv = 0;
    start = 1'b1; base_addr = 32'h4000; burst_len = 8'd2; num_bursts = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    arv += int'(arvalid);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_cyc1: got busy=%0d done=%0d required 1/0", busy, done);
    end
    @(posedge clk); #1;
    arv += int'(arvalid);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_done: got done=%0d busy=%0d required 1/0", done, busy);
    end
    n_cmp++;
    if (err_count !== 16'd0 || beat_count !== 32'd0) begin
      n_bad++;
      $display("FAIL zero_counts: got err=%0d beats=%0d required 0/0", err_count, beat_count);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      arv += int'(arvalid);
      arv += int'(done) * 100;
    end
    n_cmp++;
    if (arv != 0) begin
      n_bad++;
      $display("FAIL zero_quiet: got activity code %0d required 0", arv);
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] seen [$];
    int cyc;
    start = 1'b1; base_addr = 32'hFFFF_FFF0; burst_len = 8'd3; num_bursts = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    arready = 1'b1; rdata = EXP; rresp = 2'b00; rid = 8'd0; rlast = 1'b0; rvalid = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      if (arvalid) begin
        seen.push_back(araddr);
        rid = arid;
      end
      rvalid = 1'b1;
      rlast = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    rvalid = 1'b0; arready = 1'b0;
    n_cmp++;
    if (seen.size() != 2) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d AR required 2", seen.size());
    end else begin
      n_cmp++;
      if (seen[0] !== 32'hFFFF_FFF0 || seen[1] !== 32'h0000_0000) begin
        n_bad++;
        $display("FAIL wrap_addr: got %h,%h required fffffff0,00000000", seen[0], seen[1]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int acc;
    bit hs, hs_n;
    acc = 0; hs = 1'b0;
    start = 1'b1; base_addr = 32'h2000; burst_len = 8'd3; num_bursts = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      arready = 1'b1;
      rvalid = hs; rdata = EXP; rid = 8'd0; rresp = 2'b00; rlast = 1'b0;
      hs_n = hs | arvalid;
      if (rvalid && rready) begin
        acc++;
        if (acc == 2) rstn = 1'b0;
      end
      hs = hs_n;
      @(posedge clk); #1;
      if (acc == 2) break;
    end
    n_cmp++;
    if (acc != 2) begin
      n_bad++;
      $display("FAIL rstmid_reach: got %0d beats required 2", acc);
    end
    n_cmp++;
    if ({arvalid, arid, araddr, arlen, rready, busy, done, err_count, beat_count} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got busy=%0d rready=%0d beats=%0d araddr=%h required all 0",
               busy, rready, beat_count, araddr);
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (beat_count !== 32'd0 || rready !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_ignored: got beats=%0d rready=%0d required 0/0", beat_count, rready);
    end
    rvalid = 1'b0; arready = 1'b0;
    test_basic("after_reset", 32'h3000, 8'd2, 16'd3, EXP, 0, 1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      test_basic("random", $urandom, 8'($urandom_range(0, 15)), 16'($urandom_range(1, 6)),
                 EXP, 2, $urandom_range(0, 3), 1'b1, 1'b1);
    end
  endtask

  initial begin
    start = 1'b0; base_addr = '0; burst_len = '0; num_bursts = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    test_reset();
    test_basic("const_ok", 32'h1000, 8'd3, 16'd4, EXP, 0, 0, 1'b0, 1'b0);
    test_zero_bursts();
    test_basic("all_err", 32'h0, 8'd0, 16'd5, 32'h0, 0, 0, 1'b0, 1'b0);
    test_basic("rlast_fault", 32'h800, 8'd3, 16'd2, EXP, 1, 0, 1'b0, 1'b0);
    test_basic("backpressure", 32'h1000, 8'd3, 16'd4, EXP, 0, 10, 1'b1, 1'b1);
    test_addr_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
